// File: rtl/idex_skid_stage.sv
// ID/EX two-entry skid stage with flush, hold and a saturating stall counter.
// Decode pushes into main/skid; execute pops from main in FIFO order.
module idex_skid_stage #(
  parameter int DATA_W = 704,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic              hold,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] FULL  = 2'd1;
  localparam logic [1:0] SKID  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              accept;
  logic              rel;

  // Handshake signals and head-entry outputs
  always_comb begin
    in_ready  = !reset && (state_q != SKID)
                && !hold && !flush;
    out_valid = (state_q != EMPTY);
    out_data  = out_valid ? main_data_q : '0;
    out_ctrl  = out_valid ? main_ctrl_q : '0;
    occupancy = state_q;
    stall_cnt = stall_cnt_q;
    accept    = in_valid && in_ready;
    rel       = out_valid && out_ready && !hold;
  end

  // Next-state and entry movement; flush wins over everything
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d     = EMPTY;
      main_data_d = '0;
      main_ctrl_d = '0;
      skid_data_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
            state_d     = FULL;
          end
        end
        FULL: begin
          if (accept && rel) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (accept) begin
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
            state_d     = SKID;
          end else if (rel) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (rel) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            state_d     = FULL;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Saturating count of cycles stalled by execute
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && !flush
        && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // State and storage registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_idex_skid_stage.sv
// Directed bench for idex_skid_stage.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_idex_skid_stage;
  localparam int DW = 704;
  localparam int CW = 16;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          flush;
  logic          hold;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cnt;

  logic          in_ready2;
  logic          out_valid2;
  logic [7:0]    out_data2;
  logic [CW-1:0] out_ctrl2;
  logic [1:0]    occupancy2;
  logic [1:0]    stall_cnt2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  idex_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl),
    .flush(flush), .hold(hold),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  idex_skid_stage #(.DATA_W(8), .CTRL_W(CW), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data[7:0]), .in_ctrl(in_ctrl),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_ctrl(out_ctrl2),
    .flush(flush), .hold(hold),
    .occupancy(occupancy2), .stall_cnt(stall_cnt2)
  );

  function automatic logic [DW-1:0] pat(input int k);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < DW / 32; i++)
      v[i*32 +: 32] = 32'(k) * 32'h0101_0101 + 32'(i);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_ctrl = 16'h5; in_data = pat(5);
    out_ready = 1'b1; flush = 1'b0; hold = 1'b0;
    tick();
    @(negedge clk);
    tests++;
    if (occupancy !== 2'd0) begin
      fails++; $display("FAIL rst_occ got %0d exp 0", occupancy);
    end
    tests++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0) begin
      fails++; $display("FAIL rst_out got v=%0b c=%0h exp v=0 c=0", out_valid, out_ctrl);
    end
    tests++;
    if (in_ready !== 1'b0 || stall_cnt !== '0) begin
      fails++; $display("FAIL rst_rdy got rdy=%0b cnt=%0d exp 0 0", in_ready, stall_cnt);
    end
    tick();
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL rst_first_rdy got %0b exp 1", in_ready);
    end
    tick();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      in_valid = (k <= 8);
      in_ctrl  = CW'(k);
      in_data  = pat(k);
      @(negedge clk);
      if (k > 1) begin
        tests++;
        if (out_valid !== 1'b1 || out_ctrl !== CW'(k-1)) begin
          fails++; $display("FAIL stream_ctrl got v=%0b c=%0h exp v=1 c=%0h", out_valid, out_ctrl, k-1);
        end
        tests++;
        if (out_data !== pat(k-1) || occupancy !== 2'd1) begin
          fails++; $display("FAIL stream_data got occ=%0d d=%0h exp occ=1 d=%0h", occupancy, out_data, pat(k-1));
        end
      end
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (occupancy !== 2'd0 || stall_cnt !== '0) begin
      fails++; $display("FAIL stream_end got occ=%0d cnt=%0d exp 0 0", occupancy, stall_cnt);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1;
    in_ctrl = 16'h00A1; in_data = pat(161);
    tick();
    in_ctrl = 16'h00B2; in_data = pat(178);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      fails++; $display("FAIL bp_full got occ=%0d rdy=%0b exp 2 0", occupancy, in_ready);
    end
    tests++;
    if (out_ctrl !== 16'h00A1) begin
      fails++; $display("FAIL bp_head got %0h exp a1", out_ctrl);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (out_ctrl !== 16'h00A1 || out_data !== pat(161)) begin
      fails++; $display("FAIL bp_relA got %0h exp a1", out_ctrl);
    end
    tick();
    @(negedge clk);
    tests++;
    if (out_ctrl !== 16'h00B2 || out_data !== pat(178)) begin
      fails++; $display("FAIL bp_relB got %0h exp b2", out_ctrl);
    end
    tests++;
    if (in_ready !== 1'b1 || occupancy !== 2'd1) begin
      fails++; $display("FAIL bp_rdy got rdy=%0b occ=%0d exp 1 1", in_ready, occupancy);
    end
    tick();
    @(negedge clk);
    tests++;
    if (occupancy !== 2'd0 || stall_cnt !== 16'd2) begin
      fails++; $display("FAIL bp_end got occ=%0d cnt=%0d exp 0 2", occupancy, stall_cnt);
    end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_ctrl = 16'h0011; in_data = pat(17);
    tick();
    in_ctrl = 16'h0022; in_data = pat(34);
    tick();
    flush = 1'b1;
    in_ctrl = 16'h00CC; in_data = pat(204);
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0 || occupancy !== 2'd2) begin
      fails++; $display("FAIL fl_pre got rdy=%0b occ=%0d exp 0 2", in_ready, occupancy);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== '0) begin
      fails++; $display("FAIL fl_clear got occ=%0d v=%0b c=%0h exp 0 0 0", occupancy, out_valid, out_ctrl);
    end
    tests++;
    if (out_data !== '0 || stall_cnt !== 16'd3) begin
      fails++; $display("FAIL fl_cnt got cnt=%0d exp 3", stall_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0) begin
        fails++; $display("FAIL fl_leak got v=%0b c=%0h exp v=0", out_valid, out_ctrl);
      end
    end
    tick();
  endtask

  task automatic test_hold();
    out_ready = 1'b1; in_valid = 1'b1;
    in_ctrl = 16'h0E01; in_data = pat(1);
    tick();
    hold = 1'b1; in_ctrl = 16'h0E02; in_data = pat(2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (out_ctrl !== 16'h0E01 || in_ready !== 1'b0) begin
        fails++; $display("FAIL hold_out got c=%0h rdy=%0b exp e01 0", out_ctrl, in_ready);
      end
      tests++;
      if (occupancy !== 2'd1 || stall_cnt !== 16'd3) begin
        fails++; $display("FAIL hold_cnt got occ=%0d cnt=%0d exp 1 3", occupancy, stall_cnt);
      end
      tick();
    end
    hold = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_ctrl !== 16'h0E01) begin
      fails++; $display("FAIL hold_rel got v=%0b c=%0h exp 1 e01", out_valid, out_ctrl);
    end
    tick();
    @(negedge clk);
    tests++;
    if (occupancy !== 2'd0) begin
      fails++; $display("FAIL hold_end got occ=%0d exp 0", occupancy);
    end
    tick();
  endtask

  task automatic test_stall_sat();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    #2 reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1;
    in_ctrl = 16'h0777; in_data = pat(7);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      tests++;
      if (stall_cnt2 !== exp_cnt[i]) begin
        fails++; $display("FAIL sat_cnt%0d got %0d exp %0d", i, stall_cnt2, exp_cnt[i]);
      end
    end
    tests++;
    if (stall_cnt !== 16'd5) begin
      fails++; $display("FAIL sat_wide got %0d exp 5", stall_cnt);
    end
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_ctrl = 16'h0A0A; in_data = pat(10);
    tick();
    in_ctrl = 16'h0B0B; in_data = pat(11);
    tick();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    tests++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== '0) begin
      fails++; $display("FAIL ar_out got occ=%0d v=%0b c=%0h exp 0 0 0", occupancy, out_valid, out_ctrl);
    end
    tests++;
    if (in_ready !== 1'b0 || stall_cnt !== '0 || out_data !== '0) begin
      fails++; $display("FAIL ar_rdy got rdy=%0b cnt=%0d exp 0 0", in_ready, stall_cnt);
    end
    tick();
    reset = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    in_ctrl = 16'h0D0D; in_data = pat(13);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL ar_push got v=%0b rdy=%0b exp 0 1", out_valid, in_ready);
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_ctrl !== 16'h0D0D || out_data !== pat(13)) begin
      fails++; $display("FAIL ar_lat got v=%0b c=%0h exp 1 d0d", out_valid, out_ctrl);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_hold();
    test_stall_sat();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
